// File: rtl/pwm_reader_block_pkg.sv
// rtl/pwm_reader_block_pkg.sv - shared timing constants, state encoding and command scaling for the RC PWM reader
package pwm_reader_block_pkg;

    localparam int MIN_PWM_TIME_HIGH_US = 1000;
    localparam int MAX_PWM_TIME_HIGH_US = 2000;
    localparam int PWM_PERIOD_US        = 20000;
    localparam int RX_PWM_TIMEOUT_US    = 25000;

    localparam int HIGH_COUNT_W = 12;
    localparam int TIMEOUT_W    = 16;

    typedef enum logic [2:0] {
        WAIT_LOW  = 3'b001,
        WAIT_RISE = 3'b010,
        MEASURE   = 3'b100
    } rx_state_t;

    // Map an accepted high time onto the 0..1000 throttle command, clamping the
    // 1000..2000 us nominal window at both ends.
    function automatic logic [9:0] width_to_cmd(input logic [HIGH_COUNT_W-1:0] width);
        logic [9:0]              cmd;
        logic [HIGH_COUNT_W-1:0] offset;
        offset = width - HIGH_COUNT_W'(MIN_PWM_TIME_HIGH_US);
        if (width < HIGH_COUNT_W'(MIN_PWM_TIME_HIGH_US)) begin
            cmd = 10'd0;
        end else if (width > HIGH_COUNT_W'(MAX_PWM_TIME_HIGH_US)) begin
            cmd = 10'd1000;
        end else begin
            cmd = offset[9:0];
        end
        return cmd;
    endfunction

endpackage

// File: rtl/pwm_input_sync_edge.sv
// rtl/pwm_input_sync_edge.sv - two-flop synchronizer plus rise/fall detect for the receiver PWM line
module pwm_input_sync_edge (
    input  logic us_clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s2,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s3;

    always_ff @(posedge us_clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/pwm_reader_block.sv
// rtl/pwm_reader_block.sv - RC receiver PWM channel decoder with range check and signal-loss timeout
module pwm_reader_block
    import pwm_reader_block_pkg::*;
#(
    parameter int OUTPUT_BIT_WIDTH = 10,
    parameter int MIN_VALID_US     = 800,
    parameter int MAX_VALID_US     = 2200,
    parameter int TIMEOUT_US       = RX_PWM_TIMEOUT_US
) (
    input  logic                        us_clk,
    input  logic                        reset,
    input  logic                        pwm_in,
    output logic [OUTPUT_BIT_WIDTH-1:0] pwm_value,
    output logic                        value_valid,
    output logic                        pulse_error,
    output logic                        signal_lost
);

    localparam logic [HIGH_COUNT_W-1:0] MIN_W   = HIGH_COUNT_W'(MIN_VALID_US);
    localparam logic [HIGH_COUNT_W-1:0] MAX_W   = HIGH_COUNT_W'(MAX_VALID_US);
    localparam logic [HIGH_COUNT_W-1:0] HC_SAT  = '1;
    localparam logic [TIMEOUT_W-1:0]    TO_END  = TIMEOUT_W'(TIMEOUT_US);
    localparam logic [TIMEOUT_W-1:0]    TO_LAST = TIMEOUT_W'(TIMEOUT_US - 1);

    logic s2;
    logic rise;
    logic fall;

    pwm_input_sync_edge u_sync (
        .us_clk (us_clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .s2     (s2),
        .rise   (rise),
        .fall   (fall)
    );

    rx_state_t                 state;
    logic [HIGH_COUNT_W-1:0]   high_count;
    logic [HIGH_COUNT_W-1:0]   width;
    logic                      eval_pending;
    logic [1:0]                prime_cnt;
    logic [TIMEOUT_W-1:0]      timeout_cnt;

    logic                        primed;
    logic                        width_ok;
    logic [OUTPUT_BIT_WIDTH-1:0] cmd_value;

    // The synchronizer holds zeros through reset, so s2 only reflects the real
    // line two samples later; until then a high line must not look like "low".
    assign primed    = (prime_cnt == 2'd2);
    assign width_ok  = eval_pending && (width >= MIN_W) && (width <= MAX_W);
    assign cmd_value = OUTPUT_BIT_WIDTH'(width_to_cmd(width));

    always_ff @(posedge us_clk) begin
        if (reset) begin
            state        <= WAIT_LOW;
            high_count   <= '0;
            width        <= '0;
            eval_pending <= 1'b0;
            prime_cnt    <= 2'd0;
            timeout_cnt  <= '0;
            pwm_value    <= '0;
            value_valid  <= 1'b0;
            pulse_error  <= 1'b0;
            signal_lost  <= 1'b1;
        end else begin
            value_valid  <= 1'b0;
            pulse_error  <= 1'b0;
            eval_pending <= 1'b0;

            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end

            case (state)
                WAIT_LOW: begin
                    if (primed && !s2) begin
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        high_count <= HIGH_COUNT_W'(1);
                        state      <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        width        <= high_count;
                        eval_pending <= 1'b1;
                        state        <= WAIT_RISE;
                    end else if (s2) begin
                        if (high_count == MAX_W) begin
                            // Too long: reject now and ignore the eventual fall.
                            high_count  <= high_count + HIGH_COUNT_W'(1);
                            pulse_error <= 1'b1;
                            state       <= WAIT_LOW;
                        end else if (high_count != HC_SAT) begin
                            high_count <= high_count + HIGH_COUNT_W'(1);
                        end
                    end else begin
                        state <= WAIT_RISE;
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                end
            endcase

            // Acceptance takes priority over a timeout expiring in the same cycle.
            if (width_ok) begin
                value_valid <= 1'b1;
                pwm_value   <= cmd_value;
                timeout_cnt <= '0;
                signal_lost <= 1'b0;
            end else begin
                if (eval_pending) begin
                    pulse_error <= 1'b1;
                end
                if (timeout_cnt != TO_END) begin
                    timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
                    if (timeout_cnt == TO_LAST) begin
                        signal_lost <= 1'b1;
                        pwm_value   <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_reader_block.sv
// tb/tb_pwm_reader_block.sv - directed self-checking bench for pwm_reader_block
`timescale 1ns/1ps
module tb_pwm_reader_block;

    logic       us_clk = 1'b0;
    logic       reset  = 1'b1;
    logic       pwm_in = 1'b0;
    logic [9:0] pwm_value;
    logic       value_valid;
    logic       pulse_error;
    logic       signal_lost;

    pwm_reader_block dut (
        .us_clk      (us_clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .pwm_value   (pwm_value),
        .value_valid (value_valid),
        .pulse_error (pulse_error),
        .signal_lost (signal_lost)
    );

    always #5 us_clk = ~us_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vv_count = 0, vv_cyc = -1, vv_val = -1, vv_lost = -1;
    int pe_count = 0, pe_cyc = -1;
    int both_count = 0;
    int lost_cyc = -1;
    logic prev_lost = 1'b0;

    always @(posedge us_clk) cyc++;

    always @(negedge us_clk) begin
        if (value_valid) begin
            vv_count++;
            vv_cyc  = cyc;
            vv_val  = int'(pwm_value);
            vv_lost = int'(signal_lost);
        end
        if (pulse_error) begin
            pe_count++;
            pe_cyc = cyc;
        end
        if (value_valid && pulse_error) both_count++;
        if (signal_lost && !prev_lost) lost_cyc = cyc;
        prev_lost = signal_lost;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // rise_edge: first posedge sampling high; fall_edge: first posedge sampling low.
    task automatic pulse(input int n, output int rise_edge, output int fall_edge);
        @(negedge us_clk);
        pwm_in = 1'b1;
        rise_edge = cyc + 1;
        repeat (n) @(negedge us_clk);
        pwm_in = 1'b0;
        fall_edge = cyc + 1;
        repeat (20) @(negedge us_clk);
    endtask

    int good_w[6] = '{1000, 2000, 950, 2100, 800, 2200};
    int good_v[6] = '{0, 1000, 0, 1000, 0, 1000};
    int bad_w[2]  = '{500, 799};
    int long_w[2] = '{2201, 2500};

    initial begin
        int r, f, vc, pc;

        repeat (5) @(negedge us_clk);
        check("reset_value", int'(pwm_value), 0);
        check("reset_valid", int'(value_valid), 0);
        check("reset_error", int'(pulse_error), 0);
        check("reset_lost", int'(signal_lost), 1);
        reset = 1'b0;
        repeat (100) @(negedge us_clk);

        vc = vv_count; pc = pe_count;
        pulse(1500, r, f);
        check("p1500_count", vv_count - vc, 1);
        check("p1500_value", vv_val, 500);
        check("p1500_lost", vv_lost, 0);
        check("p1500_latency", vv_cyc, f + 3);
        check("p1500_noerr", pe_count - pc, 0);

        for (int i = 0; i < 6; i++) begin
            vc = vv_count;
            pulse(good_w[i], r, f);
            check($sformatf("good%0d_count", good_w[i]), vv_count - vc, 1);
            check($sformatf("good%0d_value", good_w[i]), vv_val, good_v[i]);
        end

        for (int i = 0; i < 2; i++) begin
            vc = vv_count; pc = pe_count;
            pulse(bad_w[i], r, f);
            check($sformatf("short%0d_err", bad_w[i]), pe_count - pc, 1);
            check($sformatf("short%0d_errcyc", bad_w[i]), pe_cyc, f + 3);
            check($sformatf("short%0d_novalid", bad_w[i]), vv_count - vc, 0);
            check($sformatf("short%0d_hold", bad_w[i]), int'(pwm_value), 1000);
        end

        for (int i = 0; i < 2; i++) begin
            vc = vv_count; pc = pe_count;
            pulse(long_w[i], r, f);
            check($sformatf("long%0d_err", long_w[i]), pe_count - pc, 1);
            check($sformatf("long%0d_errcyc", long_w[i]), pe_cyc, r + 2202);
            check($sformatf("long%0d_novalid", long_w[i]), vv_count - vc, 0);
        end

        // line already high when reset releases
        vc = vv_count; pc = pe_count;
        @(negedge us_clk);
        pwm_in = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge us_clk);
        reset = 1'b0;
        repeat (300) @(negedge us_clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge us_clk);
        check("cut_novalid", vv_count - vc, 0);
        check("cut_noerr", pe_count - pc, 0);
        pulse(1200, r, f);
        check("p1200_value", vv_val, 200);
        check("p1200_lost", vv_lost, 0);

        pulse(1800, r, f);
        check("p1800a_value", vv_val, 800);
        check("p1800a_lost", vv_lost, 0);
        lost_cyc = -1;
        repeat (25010) @(negedge us_clk);
        check("timeout_cycle", lost_cyc, vv_cyc + 25000);
        check("timeout_lost", int'(signal_lost), 1);
        check("timeout_value", int'(pwm_value), 0);
        vc = vv_count;
        pulse(1800, r, f);
        check("p1800b_count", vv_count - vc, 1);
        check("p1800b_value", vv_val, 800);
        check("p1800b_lost", int'(signal_lost), 0);

        // reset in the middle of a measurement
        vc = vv_count; pc = pe_count;
        @(negedge us_clk);
        pwm_in = 1'b1;
        repeat (500) @(negedge us_clk);
        reset = 1'b1;
        @(negedge us_clk);
        check("midrst_value", int'(pwm_value), 0);
        check("midrst_valid", int'(value_valid), 0);
        check("midrst_error", int'(pulse_error), 0);
        check("midrst_lost", int'(signal_lost), 1);
        repeat (2) @(negedge us_clk);
        reset = 1'b0;
        repeat (700) @(negedge us_clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge us_clk);
        check("midrst_novalid", vv_count - vc, 0);
        check("midrst_noerr", pe_count - pc, 0);

        check("never_both", both_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_reader_block.md
Name: pwm_reader_block

Overview:
- Decodes one RC-receiver PWM channel, which is the input-side counterpart of the ESC PWM generator.
- Measures the high time of each incoming pulse in microseconds and range-checks it.
- Publishes a 0..1000 command value with a one-cycle valid strobe.
- Declares signal loss when no valid pulse arrives within a timeout; the flight controller then goes to failsafe.
- One instance per receiver channel, clocked by the 1 MHz us_clk.

Parameters:
- OUTPUT_BIT_WIDTH, 10: width of pwm_value. Must be >= 10.
- MIN_VALID_US, 800: shortest high time accepted as a real pulse.
- MAX_VALID_US, 2200: longest high time accepted as a real pulse.
- TIMEOUT_US, 25000: us_clk cycles without an accepted pulse before signal_lost asserts. Must be < 65536.

Ports:
- us_clk  in  1  1 MHz clock (1 us period)
- reset  in  1  synchronous, active-high reset
- pwm_in  in  1  asynchronous PWM from the receiver
- pwm_value  out  OUTPUT_BIT_WIDTH  decoded command, 0..1000
- value_valid  out  1  one-cycle strobe; pwm_value updated this cycle
- pulse_error  out  1  one-cycle strobe; pulse rejected (too short or too long)
- signal_lost  out  1  level; no accepted pulse within TIMEOUT_US

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - pwm_value = 0, value_valid = 0, pulse_error = 0.
  - signal_lost = 1 (no signal yet).
  - timeout counter = 0; state = WAIT_LOW.
- Input conditioning:
  - pwm_in passes through a 2-flop synchronizer (s2), then a previous-sample flop (s3).
  - rise = s2 & ~s3; fall = ~s2 & s3.
- States:
  - WAIT_LOW: discard any pulse in progress.
    - Go to WAIT_RISE when s2 == 0.
    - Reset enters WAIT_LOW, so a pulse cut by reset release is never measured.
  - WAIT_RISE: on rise, load high_count = 1 and go to MEASURE.
  - MEASURE: high_count increments (saturating, 12 bits) every cycle s2 == 1.
    - On fall: evaluate width = high_count, then go to WAIT_RISE.
    - If high_count reaches MAX_VALID_US + 1 while s2 == 1: pulse_error = 1 for one cycle, go to WAIT_LOW. Nothing is evaluated later for that pulse.
- A high time of N us yields width = N.
- Evaluation, in the cycle after fall:
  - If MIN_VALID_US <= width <= MAX_VALID_US: accepted.
    - value_valid = 1 for one cycle.
    - pwm_value = 0 if width < `MIN_PWM_TIME_HIGH_US (1000).
    - pwm_value = 1000 if width > `MAX_PWM_TIME_HIGH_US (2000).
    - Otherwise pwm_value = width - 1000, zero-extended to OUTPUT_BIT_WIDTH.
  - Otherwise (too short): pulse_error = 1 for one cycle; pwm_value holds.
- Latency: value_valid asserts on the 4th us_clk edge after pwm_in is first sampled low (sync 2 + edge 1 + evaluation 1).
- Timeout:
  - 16-bit counter cleared on every accepted pulse, saturating at TIMEOUT_US.
  - When it reaches TIMEOUT_US: signal_lost = 1 and pwm_value forced to 0 (zero-throttle failsafe).
  - signal_lost clears in the same cycle as the next value_valid.
  - Rejected pulses do not clear the counter.
- Simultaneous events:
  - Acceptance and timeout expiry in the same cycle: acceptance wins. The counter clears, signal_lost = 0, pwm_value takes the new value.
  - value_valid and pulse_error are never asserted together.
- Reset mid-pulse:
  - Outputs return to reset values on the next edge.
  - The current pulse is discarded via WAIT_LOW.
- Input stuck low: no strobes; signal_lost after TIMEOUT_US.
- Input stuck high: one pulse_error, then no strobes; signal_lost after TIMEOUT_US.

Decomposition:
- common_defines.v holds:
  - `MIN_PWM_TIME_HIGH_US (1000), `MAX_PWM_TIME_HIGH_US (2000), `PWM_PERIOD_US (20000).
  - New: `RX_PWM_TIMEOUT_US (25000), used as the TIMEOUT_US default.
  - New: state encodings WAIT_LOW / WAIT_RISE / MEASURE, one-hot 3'b001 / 3'b010 / 3'b100.
- One sub-module: pwm_input_sync_edge.
  - Contains the 2-flop synchronizer plus edge detect.
  - Outputs: s2, rise, fall.
  - Resets to 0 with reset.

Test Plan:
- 1500 us high pulse, 20000 us period, after reset → first full pulse gives value_valid, pwm_value = 500, signal_lost falls to 0 in the same cycle.
- Pulses of 1000, 2000, 950 and 2100 us → pwm_value = 0, 1000, 0, 1000 respectively, each with value_valid.
- 500 us glitch → pulse_error one cycle, no value_valid, pwm_value unchanged. 2500 us pulse → pulse_error at high_count = 2201, then no further strobe when it ends.
- pwm_in high when reset deasserts, pulse ends 300 us later → no strobe. Next 1200 us pulse → pwm_value = 200.
- Valid 1800 us pulses stop → signal_lost = 1 and pwm_value = 0 exactly 25000 cycles after the last value_valid. Next 1800 us pulse → pwm_value = 800, signal_lost = 0.
- Latency check: pwm_in falls at a known edge → value_valid exactly on the 4th us_clk edge after. Reset asserted mid-MEASURE → all outputs at reset values on the next edge.
